// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   IFU_ADDR_WIDTH : default fetch address width
//   IFU_DATA_WIDTH : default fetch data width
//   ifu_state_e    : fetch-bus arbiter state (idle / address phase / data phase)
package ifu_pkg;

   localparam int unsigned IFU_ADDR_WIDTH = 48;
   localparam int unsigned IFU_DATA_WIDTH = 128;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAr   = 2'd1,
      StR    = 2'd2
   } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_arb_if.sv
// Fetch-bus bundle between NUM_REQ requesters, the arbiter and the shared bus.
//   req_*  : per-requester AR/R handshakes, packed per requester
//   bus_*  : single shared AR/R bus
//   master : arbiter view; slave : requesters plus bus (the environment)
interface ifu_fetch_arb_if
   import ifu_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = IFU_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = IFU_DATA_WIDTH
) ();

   logic [NUM_REQ*ADDR_WIDTH-1:0] req_ar;
   logic [NUM_REQ-1:0]            req_ar_valid;
   logic [NUM_REQ-1:0]            req_ar_ready;
   logic [NUM_REQ-1:0]            req_r_valid;
   logic [NUM_REQ-1:0]            req_r_ready;
   logic [DATA_WIDTH-1:0]         req_r_data;
   logic [NUM_REQ-1:0]            req_flush;

   logic [ADDR_WIDTH-1:0]         bus_ar;
   logic                          bus_ar_valid;
   logic                          bus_ar_ready;
   logic                          bus_r_valid;
   logic                          bus_r_ready;
   logic [DATA_WIDTH-1:0]         bus_r_data;

   modport master (
      input  req_ar, req_ar_valid, req_r_ready, req_flush,
      input  bus_ar_ready, bus_r_valid, bus_r_data,
      output req_ar_ready, req_r_valid, req_r_data,
      output bus_ar, bus_ar_valid, bus_r_ready
   );

   modport slave (
      output req_ar, req_ar_valid, req_r_ready, req_flush,
      output bus_ar_ready, bus_r_valid, bus_r_data,
      input  req_ar_ready, req_r_valid, req_r_data,
      input  bus_ar, bus_ar_valid, bus_r_ready
   );

endinterface

// File: rtl/ifu_fetch_arb_rr_pick.sv
// Combinational round-robin priority picker.
//   req  : request vector
//   last : index of the previous winner (searched last)
//   gnt  : one-hot grant
//   idx  : index of the granted bit
//   any  : at least one request set
module rr_pick #(
   parameter int unsigned  NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      // Start one past the last winner and wrap, so the last winner has lowest priority.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         if (!any && req[(int'(last) + k) % NUM_REQ]) begin
            any = 1'b1;
            idx = ID_W'((int'(last) + k) % NUM_REQ);
         end
      end
      if (any) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/ifu_fetch_arb.sv
// Shares one instruction-fetch bus (AR + R channels) between NUM_REQ requesters.
// Round-robin grant, one outstanding transaction, R data routed to the granted
// requester, per-requester flush that lets the bus transaction finish but drops the data.
//   clk, rst : clock, asynchronous active-high reset
//   fetch    : requester and bus handshakes (master modport)
//   grant_id : index of the current / last granted requester
//   busy     : a transaction is in progress
module ifu_fetch_arb
   import ifu_pkg::*;
#(
   parameter int unsigned  NUM_REQ    = 4,
   parameter int unsigned  ADDR_WIDTH = IFU_ADDR_WIDTH,
   parameter int unsigned  DATA_WIDTH = IFU_DATA_WIDTH,
   localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
   input  logic                   clk,
   input  logic                   rst,
   ifu_fetch_arb_if.master        fetch,
   output logic [ID_W-1:0]        grant_id,
   output logic                   busy
);

   ifu_state_e            state_q, state_d;
   logic [ID_W-1:0]       grant_q, grant_d;
   logic [ADDR_WIDTH-1:0] ar_q, ar_d;
   logic                  ar_valid_q, ar_valid_d;
   logic                  drop_q, drop_d;

   logic [NUM_REQ-1:0]    pick_gnt;
   logic [ID_W-1:0]       pick_idx;
   logic                  pick_any;
   logic                  r_ready;
   logic [DATA_WIDTH-1:0] r_data;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req  (fetch.req_ar_valid),
      .last (grant_q),
      .gnt  (pick_gnt),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   always_comb begin
      state_d            = state_q;
      grant_d            = grant_q;
      ar_d               = ar_q;
      ar_valid_d         = ar_valid_q;
      drop_d             = drop_q;
      r_ready            = 1'b0;
      fetch.req_ar_ready = '0;
      fetch.req_r_valid  = '0;

      unique case (state_q)
         StIdle: begin
            if (pick_any) begin
               fetch.req_ar_ready = pick_gnt;
               grant_d            = pick_idx;
               ar_d               = fetch.req_ar[int'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
               ar_valid_d         = 1'b1;
               drop_d             = fetch.req_flush[pick_idx];
               state_d            = StAr;
            end
         end
         StAr: begin
            // AR valid stays up through a flush; only the returned data is dropped.
            if (fetch.req_flush[grant_q]) drop_d = 1'b1;
            if (fetch.bus_ar_ready) begin
               ar_valid_d = 1'b0;
               state_d    = StR;
            end
         end
         StR: begin
            // A dropped beat is always accepted so the bus never waits on a flushed requester.
            r_ready = drop_q | fetch.req_r_ready[grant_q];
            fetch.req_r_valid[grant_q] = fetch.bus_r_valid & ~drop_q & ~fetch.req_flush[grant_q];
            if (fetch.req_flush[grant_q]) drop_d = 1'b1;
            if (fetch.bus_r_valid && r_ready) begin
               state_d = StIdle;
               drop_d  = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         grant_q    <= ID_W'(NUM_REQ - 1);
         ar_q       <= '0;
         ar_valid_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         ar_q       <= ar_d;
         ar_valid_q <= ar_valid_d;
         drop_q     <= drop_d;
      end
   end

   assign r_data             = fetch.bus_r_data;
   assign fetch.req_r_data   = r_data;
   assign fetch.bus_r_ready  = r_ready;
   assign fetch.bus_ar       = ar_q;
   assign fetch.bus_ar_valid = ar_valid_q;
   assign grant_id           = grant_q;
   assign busy               = (state_q != StIdle);

endmodule

// File: tb/tb_ifu_fetch_arb.sv
// Self-checking bench for ifu_fetch_arb: requester stimulus from the main thread,
// a bus responder with configurable stalls, and a scoreboard monitor comparing
// every AR and R handshake against queued expectations.
module tb_ifu_fetch_arb;
   import ifu_pkg::*;

   localparam int unsigned NR = 4;
   localparam int unsigned AW = IFU_ADDR_WIDTH;
   localparam int unsigned DW = IFU_DATA_WIDTH;

   typedef struct {
      int           id;
      logic [127:0] val;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    grant_id;
   logic          busy;

   exp_t          exp_ar[$];
   exp_t          exp_r[$];
   int            checks   = 0;
   int            failures = 0;

   int            ar_stall  = 0;
   int            r_delay   = 0;
   bit            use_fixed = 0;
   logic [127:0]  fixed_data = '0;
   bit            auto_drop = 1;

   ifu_fetch_arb_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) f_if ();

   ifu_fetch_arb #(
      .NUM_REQ    (NR),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .fetch    (f_if),
      .grant_id (grant_id),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [127:0] data_of(input logic [47:0] a);
      return {16'hB5B5, 64'h0123_4567_89AB_CDEF, a};
   endfunction

   // One cycle: sample accepts before the edge, land 2 time units after it.
   task automatic step();
      logic [NR-1:0] acc;
      @(negedge clk);
      acc = f_if.req_ar_ready & f_if.req_ar_valid;
      @(posedge clk);
      #2;
      if (auto_drop) f_if.req_ar_valid = f_if.req_ar_valid & ~acc;
   endtask

   task automatic do_reset();
      rst               = 1'b1;
      f_if.req_ar_valid = '0;
      f_if.req_flush    = '0;
      f_if.req_r_ready  = '1;
      exp_ar.delete();
      exp_r.delete();
      ar_stall  = 0;
      r_delay   = 0;
      use_fixed = 0;
      auto_drop = 1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic set_addr(input int id, input logic [47:0] a);
      f_if.req_ar[id*AW +: AW] = a;
   endtask

   task automatic push(input int id, input logic [47:0] a, input bit with_r, input logic [127:0] d);
      exp_t e;
      e.id = id; e.val = {80'h0, a};
      exp_ar.push_back(e);
      if (with_r) begin
         e.val = d;
         exp_r.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         if (exp_ar.size() == 0 && exp_r.size() == 0 && !busy) done = 1;
         else step();
      end
      chk_eq({tag, "_drain"}, done, 1'b1);
   endtask

   // Bus responder.
   initial begin : bus_model
      int          ph, cnt;
      logic        ar_hs, r_hs;
      logic [47:0] addr;
      ph = 0; cnt = 0; addr = '0;
      f_if.bus_ar_ready = 1'b0;
      f_if.bus_r_valid  = 1'b0;
      f_if.bus_r_data   = '0;
      forever begin
         @(negedge clk);
         ar_hs = f_if.bus_ar_valid && f_if.bus_ar_ready;
         r_hs  = f_if.bus_r_valid && f_if.bus_r_ready;
         if (ar_hs) addr = f_if.bus_ar;
         @(posedge clk);
         #1;
         if (rst) begin
            ph = 0; cnt = 0;
            f_if.bus_ar_ready = 1'b0;
            f_if.bus_r_valid  = 1'b0;
         end else if (ph == 0) begin
            if (ar_hs) begin
               f_if.bus_ar_ready = 1'b0;
               ph = 1; cnt = 0;
               if (r_delay == 0) begin
                  f_if.bus_r_valid = 1'b1;
                  f_if.bus_r_data  = use_fixed ? fixed_data : data_of(addr);
               end
            end else if (f_if.bus_ar_valid) begin
               if (cnt >= ar_stall) f_if.bus_ar_ready = 1'b1;
               else cnt++;
            end
         end else begin
            if (r_hs) begin
               f_if.bus_r_valid = 1'b0;
               ph = 0; cnt = 0;
            end else if (!f_if.bus_r_valid) begin
               cnt++;
               if (cnt >= r_delay) begin
                  f_if.bus_r_valid = 1'b1;
                  f_if.bus_r_data  = use_fixed ? fixed_data : data_of(addr);
               end
            end
         end
      end
   end

   // Scoreboard monitor.
   initial begin : monitor
      exp_t          e;
      logic [NR-1:0] oh;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (|f_if.req_ar_ready) chk_eq("ar_ready_onehot", $onehot(f_if.req_ar_ready), 1'b1);
            if (|f_if.req_r_valid) chk_eq("r_valid_onehot", $onehot(f_if.req_r_valid), 1'b1);
            if (f_if.bus_ar_valid && f_if.bus_ar_ready) begin
               chk_eq("ar_pending", exp_ar.size() != 0, 1'b1);
               if (exp_ar.size() != 0) begin
                  e = exp_ar.pop_front();
                  chk_eq("ar_addr", f_if.bus_ar, e.val);
                  chk_eq("ar_grant", grant_id, e.id);
               end
            end
            if (|(f_if.req_r_valid & f_if.req_r_ready)) begin
               chk_eq("r_pending", exp_r.size() != 0, 1'b1);
               if (exp_r.size() != 0) begin
                  e  = exp_r.pop_front();
                  oh = '0;
                  oh[e.id] = 1'b1;
                  chk_eq("r_valid_vec", f_if.req_r_valid, oh);
                  chk_eq("r_data", f_if.req_r_data, e.val);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: time %0t reached limit %0t", $time, 100000);
      $fatal(1);
   end

   initial begin : main
      bit seen;
      int n;
      rst               = 1'b1;
      f_if.req_ar       = '0;
      f_if.req_ar_valid = '0;
      f_if.req_flush    = '0;
      f_if.req_r_ready  = '1;
      step();
      // Reset values.
      chk_eq("rst_busy", busy, 1'b0);
      chk_eq("rst_grant", grant_id, 2'd3);
      chk_eq("rst_ar_valid", f_if.bus_ar_valid, 1'b0);
      chk_eq("rst_ar", f_if.bus_ar, '0);
      chk_eq("rst_r_ready", f_if.bus_r_ready, 1'b0);
      chk_eq("rst_req_ar_ready", f_if.req_ar_ready, '0);
      chk_eq("rst_req_r_valid", f_if.req_r_valid, '0);

      // Single requester, zero-wait bus.
      do_reset();
      use_fixed = 1; fixed_data = 128'hA5;
      set_addr(1, 48'h1000);
      f_if.req_ar_valid = 4'b0010;
      push(1, 48'h1000, 1, 128'hA5);
      #1;
      chk_eq("s1_ar_ready_c0", f_if.req_ar_ready, 4'b0010);
      step();
      chk_eq("s1_bus_ar_valid_c1", f_if.bus_ar_valid, 1'b1);
      chk_eq("s1_bus_ar_c1", f_if.bus_ar, 48'h1000);
      step();
      chk_eq("s1_r_valid_c2", f_if.req_r_valid, 4'b0010);
      chk_eq("s1_r_data_c2", f_if.req_r_data, 128'hA5);
      step();
      chk_eq("s1_grant_c3", grant_id, 2'd1);
      chk_eq("s1_busy_c3", busy, 1'b0);
      drain("s1");

      // All requesters valid: rotating grant order.
      do_reset();
      auto_drop = 0;
      for (int i = 0; i < 4; i++) set_addr(i, 48'h100 * (i + 1));
      push(0, 48'h100, 1, data_of(48'h100));
      push(1, 48'h200, 1, data_of(48'h200));
      push(2, 48'h300, 1, data_of(48'h300));
      push(3, 48'h400, 1, data_of(48'h400));
      push(0, 48'h100, 1, data_of(48'h100));
      f_if.req_ar_valid = 4'b1111;
      n = 0;
      for (int i = 0; i < 40 && n < 5; i++) begin
         #1;
         if (|f_if.req_ar_ready) n++;
         step();
      end
      f_if.req_ar_valid = '0;
      chk_eq("s2_grants", n, 5);
      drain("s2");

      // Bus stalls and requester back-pressure.
      do_reset();
      ar_stall = 5; r_delay = 3;
      f_if.req_r_ready = 4'b1011;
      set_addr(2, 48'h2222);
      f_if.req_ar_valid = 4'b0100;
      push(2, 48'h2222, 1, data_of(48'h2222));
      step();
      for (int i = 0; i < 5; i++) begin
         chk_eq("s3_ar_valid_held", f_if.bus_ar_valid, 1'b1);
         chk_eq("s3_ar_stable", f_if.bus_ar, 48'h2222);
         chk_eq("s3_no_r_valid", f_if.req_r_valid, '0);
         step();
      end
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (f_if.bus_r_valid) seen = 1;
         else begin
            chk_eq("s3_wait_no_r_valid", f_if.req_r_valid, '0);
            step();
         end
      end
      chk_eq("s3_data_seen", seen, 1'b1);
      for (int i = 0; i < 2; i++) begin
         chk_eq("s3_bus_r_ready_low", f_if.bus_r_ready, 1'b0);
         chk_eq("s3_r_valid_hold", f_if.req_r_valid, 4'b0100);
         step();
      end
      f_if.req_r_ready = 4'b1111;
      #1;
      chk_eq("s3_bus_r_ready_high", f_if.bus_r_ready, 1'b1);
      drain("s3");

      // Flush during AR; next grant goes to requester 1.
      do_reset();
      ar_stall = 3; use_fixed = 1; fixed_data = 128'hDEAD;
      f_if.req_r_ready = 4'b1110;
      set_addr(0, 48'h4000);
      f_if.req_ar_valid = 4'b0001;
      push(0, 48'h4000, 0, '0);
      step();
      f_if.req_flush = 4'b0001;
      set_addr(1, 48'h5000);
      set_addr(3, 48'h7000);
      f_if.req_ar_valid = 4'b1010;
      push(1, 48'h5000, 1, 128'hDEAD);
      push(3, 48'h7000, 1, 128'hDEAD);
      #1;
      chk_eq("s4_ar_valid_on_flush", f_if.bus_ar_valid, 1'b1);
      step();
      f_if.req_flush = '0;
      chk_eq("s4_ar_valid_kept", f_if.bus_ar_valid, 1'b1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         chk_eq("s4_no_r_valid0", f_if.req_r_valid[0], 1'b0);
         if (f_if.bus_r_valid && grant_id == 2'd0) begin
            chk_eq("s4_drop_r_ready", f_if.bus_r_ready, 1'b1);
            seen = 1;
         end else step();
      end
      chk_eq("s4_dead_seen", seen, 1'b1);
      drain("s4");

      // Flush in the same cycle as the R handshake.
      do_reset();
      set_addr(1, 48'h3000);
      f_if.req_ar_valid = 4'b0010;
      push(1, 48'h3000, 0, '0);
      step();
      step();
      f_if.req_flush = 4'b0010;
      #1;
      chk_eq("s5_r_valid_suppressed", f_if.req_r_valid, '0);
      chk_eq("s5_bus_r_ready", f_if.bus_r_ready, 1'b1);
      step();
      f_if.req_flush = '0;
      chk_eq("s5_idle_after", busy, 1'b0);
      drain("s5");

      // Asynchronous reset mid-R, then priority restarts at requester 0.
      do_reset();
      r_delay = 4;
      set_addr(2, 48'h6000);
      f_if.req_ar_valid = 4'b0100;
      push(2, 48'h6000, 0, '0);
      step();
      step();
      chk_eq("s6_busy_before", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_eq("s6_async_busy", busy, 1'b0);
      chk_eq("s6_async_grant", grant_id, 2'd3);
      chk_eq("s6_async_ar_valid", f_if.bus_ar_valid, 1'b0);
      chk_eq("s6_async_ar", f_if.bus_ar, '0);
      chk_eq("s6_async_r_ready", f_if.bus_r_ready, 1'b0);
      chk_eq("s6_async_r_valid", f_if.req_r_valid, '0);
      step();
      rst = 1'b0;
      set_addr(0, 48'h8000);
      set_addr(3, 48'h9000);
      f_if.req_ar_valid = 4'b1001;
      push(0, 48'h8000, 1, data_of(48'h8000));
      push(3, 48'h9000, 1, data_of(48'h9000));
      #1;
      chk_eq("s6_first_pick", f_if.req_ar_ready, 4'b0001);
      drain("s6");

      chk_eq("left_ar", exp_ar.size(), 0);
      chk_eq("left_r", exp_r.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifu_fetch_arb.md
Name: ifu_fetch_arb

Overview:
- Shares the single instruction-fetch bus (AR address channel plus R data channel) between NUM_REQ fetch requesters, e.g. the main IFU loader and sub-IFU channel loaders.
- Round-robin arbitration; exactly one outstanding transaction at a time.
- Routes R data back to the granted requester.
- Supports per-requester flush, so a PC switch can discard an in-flight fetch without violating bus handshake rules.

Parameters:
- NUM_REQ, 4, number of fetch requesters (2..16).
- ADDR_WIDTH, 48, fetch address width.
- DATA_WIDTH, 128, fetch data width.
- ID_W, $clog2(NUM_REQ), width of the grant index (derived; not overridden).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset: asynchronous assert, active-high.
- req_ar  in  NUM_REQ*ADDR_WIDTH  packed request addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ar_valid  in  NUM_REQ  per-requester address valid.
- req_ar_ready  out  NUM_REQ  per-requester address accept; at most one bit high.
- req_r_valid  out  NUM_REQ  per-requester data valid; at most one bit high.
- req_r_ready  in  NUM_REQ  per-requester data ready.
- req_r_data  out  DATA_WIDTH  broadcast data, equal to bus_r_data.
- req_flush  in  NUM_REQ  per-requester discard of its in-flight fetch.
- bus_ar  out  ADDR_WIDTH  bus address.
- bus_ar_valid  out  1  bus address valid.
- bus_ar_ready  in  1  bus address ready.
- bus_r_valid  in  1  bus data valid.
- bus_r_ready  out  1  bus data ready.
- bus_r_data  in  DATA_WIDTH  bus data.
- grant_id  out  ID_W  index of the current/last granted requester.
- busy  out  1  high when state != IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, bus_ar=0, bus_ar_valid=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), drop=0, busy=0. All req_ar_ready, req_r_valid and bus_r_ready are 0.
- Reset mid-transaction: abandons the transaction immediately and returns to the reset values. The bus owner is reset alongside the arbiter.
- State IDLE:
  - Search req_ar_valid starting at grant_id+1, wrapping modulo NUM_REQ (round-robin); the first set bit wins, call it g.
  - req_ar_ready[g] is combinational, high in this same cycle.
  - Registered: grant_id<=g, bus_ar<=req_ar[g], bus_ar_valid<=1, drop<=req_flush[g], state<=AR.
  - No valid requester: stay IDLE.
- State AR:
  - bus_ar_valid and bus_ar are held stable until bus_ar_ready. Valid is never retracted, even on flush.
  - On bus_ar_ready: bus_ar_valid<=0, state<=R.
- State R:
  - bus_r_ready = drop | req_r_ready[grant_id].
  - req_r_valid[grant_id] = bus_r_valid & ~drop & ~req_flush[grant_id].
  - On bus_r_valid & bus_r_ready: state<=IDLE, drop<=0.
- Flush:
  - req_flush[grant_id] in AR or R sets drop<=1. The transaction completes on the bus and its data is discarded, never presented to the requester.
  - A flush in the same cycle as the R handshake suppresses req_r_valid for that beat.
  - Flush of a non-granted requester: no effect.
  - A requester wanting a new fetch after flushing re-raises req_ar_valid and competes again.
- Latency and throughput:
  - Request to bus_ar_valid: 1 cycle.
  - R handshake to next grant: 1 cycle (IDLE).
  - Peak rate: one fetch per 3 cycles with zero-wait bus.
- Fairness: a requester holding valid is granted within NUM_REQ transactions.
- grant_id updates only on grant. Simultaneous requests from all requesters are served in rotating order.
- Protocol violations are not checked: req_ar changing while valid and unaccepted, or bus_r_valid outside state R. A bus_r_valid outside R is ignored (bus_r_ready=0).

Decomposition:
- Shared package ifu_pkg:
  - IFU_ADDR_WIDTH, IFU_DATA_WIDTH.
  - State enum (IDLE=2'd0, AR=2'd1, R=2'd2).
- One natural sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: request vector, last index.
  - Outputs: one-hot grant, index, any-valid.
  - Reusable by later pipeline arbiters.

Test Plan:
- Single requester: req_ar_valid[1]=1, req_ar=48'h1000; zero-wait bus returning 128'hA5.
  - Expect req_ar_ready[1] pulse in cycle 0, bus_ar=48'h1000 valid in cycle 1.
  - Expect req_r_valid[1] with data A5 in cycle 2, grant_id=1, busy low in cycle 3.
- All 4 requesters valid continuously after reset.
  - Grant order 0,1,2,3,0; each bus_ar matches that requester's address.
- Bus stalls: bus_ar_ready low for 5 cycles, then bus_r_valid delayed 3 cycles.
  - bus_ar stays stable and valid for 5 cycles; no req_r_valid until data arrives.
  - Requester 2's req_r_ready low for 2 cycles holds bus_r_ready low.
- Flush during AR: requester 0 flushes while bus_ar_ready is low.
  - AR is still issued; data 128'hDEAD is consumed with bus_r_ready=1.
  - req_r_valid[0] never rises; the next grant goes to requester 1.
- Flush in the same cycle as the R handshake: data is not forwarded; state returns to IDLE.
- Asynchronous rst pulse mid-R: outputs go to reset values without waiting for a clock edge.
  - After release, requester 0 wins first over requester 3 when both are valid.
